// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// default frame limits and field widths.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int DEF_MAX_WORDS = 10240;
  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 16;

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit modular sum of consumed frame bytes. The zero flag already
// includes the byte currently on din, so the verdict is known on the final edge.
module loader_checksum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [BYTE_W-1:0] din,
  output logic              zero
);

  logic [BYTE_W-1:0] acc;
  logic [BYTE_W-1:0] acc_sum;

  assign acc_sum = acc + din;
  assign zero    = (acc_sum == '0);

  // Clearing and adding together restarts the sum at the first frame byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= add ? din : '0;
    end else if (add) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: writes framed 16-bit words into instruction memory
// and holds the CPU in reset until a clean load. Macro: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              CLK,
  input  logic              CtrlRst,
  input  logic [BYTE_W-1:0] ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  input  logic              Start,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [WORD_W-1:0] MemDataOut,
  output logic [WORD_W-1:0] InstrCount,
  output logic              Done,
  output logic              Error,
  output logic              CpuRst
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t LAST_STATE = CHECK;
`else
  localparam state_t LAST_STATE = DONE;
`endif

  state_t              state;
  state_t              state_next;
  logic                consume;
  logic                too_long;
  logic [BYTE_W-1:0]   hdr_hi;
  logic [BYTE_W-1:0]   data_hi;
  logic [WORD_W-1:0]   n_cur;
  logic [WORD_W-1:0]   n_reg;
  logic [WORD_W-1:0]   remaining;
  logic [WORD_W-1:0]   word_reg;
  logic [ADDR_W-1:0]   idx;

  assign consume  = ByteValid & ByteReady;
  assign n_cur    = {hdr_hi, ByteIn};
  assign too_long = {16'd0, n_cur} > 32'(MAX_WORDS);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic sum_zero;

  loader_checksum u_checksum (
    .clk  (CLK),
    .rst  (CtrlRst),
    .clr  (state == HDR_HI),
    .add  (consume),
    .din  (ByteIn),
    .zero (sum_zero)
  );
`endif

  always_comb begin
    state_next = state;
    case (state)
      HDR_HI:  if (consume) state_next = HDR_LO;
      HDR_LO: begin
        if (consume) begin
          if (too_long)            state_next = ERROR;
          else if (n_cur == '0)    state_next = LAST_STATE;
          else                     state_next = DATA_HI;
        end
      end
      DATA_HI: if (consume) state_next = DATA_LO;
      DATA_LO: if (consume) state_next = WRITE;
      WRITE:   state_next = (remaining == 16'd1) ? LAST_STATE : DATA_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK:   if (consume) state_next = sum_zero ? DONE : ERROR;
`endif
      DONE, ERROR: if (Start) state_next = HDR_HI;
      default: state_next = HDR_HI;
    endcase
  end

  always_comb begin
    ByteReady = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHECK: ByteReady = 1'b1;
      default:                                 ByteReady = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) begin
      state      <= HDR_HI;
      idx        <= '0;
      word_reg   <= '0;
      InstrCount <= '0;
    end else begin
      state <= state_next;
      if (state == HDR_LO && consume) begin
        idx <= '0;
      end else if (state == WRITE) begin
        idx <= idx + 1'b1;
      end
      if (state == DATA_LO && consume) begin
        word_reg <= {data_hi, ByteIn};
      end
      // A zero-length frame can reach DONE straight from the header.
      if (state_next == DONE && state != DONE) begin
        InstrCount <= (state == HDR_LO) ? n_cur : n_reg;
      end
    end
  end

  // Frame fields are always loaded before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (consume && state == HDR_HI) hdr_hi  <= ByteIn;
    if (consume && state == DATA_HI) data_hi <= ByteIn;
    if (state == HDR_LO && consume) begin
      n_reg     <= n_cur;
      remaining <= n_cur;
    end else if (state == WRITE) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign MemWE      = (state == WRITE);
  assign MemAddr    = BASE + idx;
  assign MemDataOut = word_reg;
  assign Done       = (state == DONE);
  assign Error      = (state == ERROR);
  assign CpuRst     = (state != DONE);

endmodule
